// File: rtl/load_store_unit.sv
// Byte-serial load/store sequencer: splits a byte/half/word access into single-byte memory beats.
// Build option LSU_ALIGN_CHECK_EN rejects misaligned half/word accesses instead of performing them bytewise.
module load_store_unit #(
  parameter int MEM_BYTES = 32
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        req_i,
  input  logic        write_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic [31:0] memAddr_o,
  output logic [31:0] memData_o,
  output logic        memRead_o,
  output logic        memWrite_o,
  input  logic [31:0] memData_i
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, stateNext;
  logic [31:0] addrQ, wdataQ, bufQ, bufNext, loadResult, rdataQ;
  logic [1:0]  sizeQ, k, lastK;
  logic        writeQ, unsQ, errQ;
  logic        accept, reqErr, misalign;
  logic [2:0]  nBytes;
  logic [32:0] endAddr;
  logic [7:0]  beatByte;
  logic [23:0] unusedMemHi;

  assign unusedMemHi = memData_i[31:8];

  // Request validation; the 33-bit end address keeps a wrap past 2^32 visible.
  always_comb begin
    case (size_i)
      2'b00:   nBytes = 3'd1;
      2'b01:   nBytes = 3'd2;
      default: nBytes = 3'd4;
    endcase
    endAddr = {1'b0, addr_i} + {30'b0, nBytes};
`ifdef LSU_ALIGN_CHECK_EN
    misalign = ((size_i == 2'b01) && addr_i[0]) ||
               ((size_i == 2'b10) && (addr_i[1:0] != 2'b00));
`else
    misalign = 1'b0;
`endif
    reqErr = (size_i == 2'b11) || (endAddr > 33'(MEM_BYTES)) || misalign;
  end

  always_comb begin
    case (sizeQ)
      2'b00:   lastK = 2'd0;
      2'b01:   lastK = 2'd1;
      default: lastK = 2'd3;
    endcase
    beatByte = wdataQ[{k, 3'b000} +: 8];
    bufNext = bufQ;
    bufNext[{k, 3'b000} +: 8] = memData_i[7:0];
    case (sizeQ)
      2'b00:   loadResult = {{24{bufNext[7] & ~unsQ}}, bufNext[7:0]};
      2'b01:   loadResult = {{16{bufNext[15] & ~unsQ}}, bufNext[15:0]};
      default: loadResult = bufNext;
    endcase
  end

  always_comb begin
    stateNext  = state;
    accept     = 1'b0;
    memRead_o  = 1'b0;
    memWrite_o = 1'b0;
    memAddr_o  = 32'b0;
    memData_o  = 32'b0;
    case (state)
      ACCESS: begin
        memAddr_o  = addrQ + {30'b0, k};
        memRead_o  = ~writeQ;
        memWrite_o = writeQ;
        if (writeQ) memData_o = {24'b0, beatByte};
        if (k == lastK) stateNext = DONE;
      end
      default: begin
        // IDLE and DONE both accept; an unused encoding falls back to IDLE.
        stateNext = IDLE;
        if (req_i) begin
          accept    = 1'b1;
          stateNext = reqErr ? DONE : ACCESS;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= IDLE;
    else          state <= stateNext;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addrQ  <= 32'b0;
      wdataQ <= 32'b0;
      sizeQ  <= 2'b0;
      writeQ <= 1'b0;
      unsQ   <= 1'b0;
      errQ   <= 1'b0;
      k      <= 2'b0;
      bufQ   <= 32'b0;
      rdataQ <= 32'b0;
    end else if (accept) begin
      addrQ  <= addr_i;
      wdataQ <= wdata_i;
      sizeQ  <= size_i;
      writeQ <= write_i;
      unsQ   <= unsigned_i;
      errQ   <= reqErr;
      k      <= 2'b0;
    end else if (state == ACCESS) begin
      k <= k + 2'd1;
      if (!writeQ) begin
        bufQ <= bufNext;
        if (k == lastK) rdataQ <= loadResult;
      end
    end
  end

  assign busy_o  = (state == ACCESS);
  assign done_o  = (state == DONE);
  assign err_o   = (state == DONE) && errQ;
  assign rdata_o = rdataQ;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator-side sequencer that drives the byte-wide data memory on behalf of the MEM stage. It accepts one load/store request at a time from the pipeline and breaks it into 1, 2 or 4 single-byte memory beats. For loads it reassembles the returned bytes little-endian and sign- or zero-extends the result. It reports completion with a one-cycle `done_o` pulse and raises `busy_o` so the pipeline can stall.

## Interface
Parameters:
- `MEM_BYTES`, default 32. Size of the data memory in bytes; used for range checking.

Ports:
- `clk_i` input 1: clock. All state changes on the rising edge.
- `rst_n_i` input 1: reset, asynchronous, active-low.
- `req_i` input 1: request valid. Sampled only when the block is not in ACCESS.
- `write_i` input 1: 1 = store, 0 = load.
- `size_i` input 2: 00 byte, 01 half, 10 word, 11 reserved.
- `unsigned_i` input 1: zero-extend byte/half loads when 1.
- `addr_i` input 32: byte address.
- `wdata_i` input 32: store data; low N bytes are used.
- `busy_o` output 1: high while in ACCESS.
- `done_o` output 1: one-cycle completion pulse.
- `err_o` output 1: valid with `done_o`; request was rejected with no memory access.
- `rdata_o` output 32: load result. Valid with `done_o` and held until the next `done_o`.
- `memAddr_o` output 32: memory byte address.
- `memData_o` output 32: memory write data, `{24'b0, byte}`.
- `memRead_o` output 1: memory read strobe.
- `memWrite_o` output 1: memory write strobe.
- `memData_i` input 32: memory read data. Only bits [7:0] are used.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- Accept condition: `req_i` high while in IDLE or DONE.
  - On accept, capture addr, wdata, size, write, unsigned.
  - Clear the beat counter `k`.
  - N = 1 for byte, 2 for half, 4 for word.
- Error check at accept. Any of the following goes directly to DONE with `err_o=1`; no strobes are ever asserted:
  - `size_i` = 11.
  - `addr_i + N > MEM_BYTES`, computed in 33 bits so 32-bit wrap does not mask the overflow.
  - Misalignment, only when the alignment check is compiled in (see Configuration).
- Valid request goes to ACCESS and runs beats k = 0..N-1, one per cycle:
  - `memAddr_o = addr + k`.
  - Store beat: `memWrite_o=1`, `memData_o = {24'b0, wdata[8k+7:8k]}`.
  - Load beat: `memRead_o=1`; byte k of an internal buffer is loaded from `memData_i[7:0]` at the end of the cycle.
  - `k` increments each cycle. After beat N-1 the FSM goes to DONE.
- DONE lasts one cycle:
  - `done_o=1`.
  - Loads: `rdata_o` = buffer, sign-extended from bit 8N-1 unless `unsigned_i`; word loads pass through.
  - Stores: `rdata_o` is held unchanged.
  - Next state: ACCESS or DONE if a new request is accepted this cycle, otherwise IDLE.
- Exactly one of `memRead_o`/`memWrite_o` is high in ACCESS; both are 0 in IDLE and DONE.
- `memAddr_o`/`memData_o` are 0 outside ACCESS.

## Timing
- Reset values: state IDLE; `busy_o`, `done_o`, `err_o`, `memRead_o`, `memWrite_o` = 0; `rdata_o`, `memAddr_o`, `memData_o` = 0.
- Latency: request accepted at edge E. Beats occupy cycles E..E+N-1, and `done_o` is high in cycle E+N.
  - Byte = 2 cycles, half = 3, word = 5.
  - Errored request: `done_o` in the cycle after E.
- Back-to-back: a request held high during DONE is accepted at that edge, so throughput is N+1 cycles per access.
- `req_i` during ACCESS is ignored. The pipeline must hold the request until it sees `done_o`.
- Reset asserted mid-ACCESS forces IDLE immediately and drops the strobes. Bytes already written stay written; no `done_o` is issued.

## Configuration
- `LSU_ALIGN_CHECK_EN` defined:
  - Half access with `addr[0]=1` is an error.
  - Word access with `addr[1:0]≠0` is an error.
- `LSU_ALIGN_CHECK_EN` undefined: misaligned accesses are performed bytewise, subject to the range check only.

## Test plan
- Reset check: reset → all outputs 0.
- Store then load word: store word 0x11223344 @4 writes mem[4..7] = 44, 33, 22, 11 on 4 consecutive cycles with `done_o` at E+4. Load word @4 then returns `rdata_o` = 0x11223344 at E+4.
- Signed/unsigned byte: with mem[9]=0x80, load byte signed @9 gives 0xFFFFFF80; `unsigned_i=1` gives 0x00000080. Load half @8 with mem[8..9]=34,80 gives 0xFFFF8034.
- Range: word @30 with `MEM_BYTES=32` → `err_o=1`, `done_o` at E+1, no strobes; a new request the next cycle is accepted.
- Back-to-back:
  - Byte store then word load, with the load held during DONE: the load is accepted on the store's DONE edge with no idle gap.
  - Store word with reset asserted after beat 1: mem[k..k+1] updated, mem[k+2..k+3] unchanged, FSM in IDLE.
- Misaligned: word @5.
  - With `LSU_ALIGN_CHECK_EN`: `err_o=1`.
  - Without it: 4 beats at addresses 5..8 and correct data.
